scan_wb_initiator: RTL and testbench
====================================

// Module: scan_wb_initiator
// PURPOSE
//  Wishbone initiator driving the scan/processor-control slave from the hardware side.
//  Takes host commands on a valid/ready stream and runs the register sequence for each:
//  scan data write, scan kick, completion poll, data readback, proc_go control, status read.
//  Sits between a host command source (bring-up UART/pin loader) and the WB slave port.
// PARAMETERS
//  POLL_MAX    256   status reads allowed per scan before the command fails (err)
//  ACK_TIMEOUT 15    cycles to wait for wbm_ack_i per transfer before the command fails
// PORTS
//  clk          in   1   single clock
//  rst_n        in   1   asynchronous, active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   high only in IDLE
//  cmd_op       in   2   0=SCAN_XCHG, 1=SET_PROC, 2=READ_STATUS, 3=reserved
//  cmd_data     in   32  SCAN_XCHG: word shifted in; SET_PROC: bit0 = proc_go
//  rsp_valid    out  1   one-cycle response strobe
//  rsp_data     out  32  SCAN_XCHG: word shifted out; READ_STATUS: status word; else 0
//  rsp_err      out  1   valid with rsp_valid; ack timeout, poll exhausted or op 3
//  wbm_cyc_o    out  1   bus cycle
//  wbm_stb_o    out  1   strobe, equal to wbm_cyc_o
//  wbm_we_o     out  1   write enable
//  wbm_sel_o    out  4   always 4'hF
//  wbm_adr_o    out  32  0x00 = scan data, 0x04 = control/status
//  wbm_dat_o    out  32  write data
//  wbm_dat_i    in   32  read data
//  wbm_ack_i    in   1   single-cycle ack
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM in IDLE; counters 0.
//  Reset mid-transfer drops cyc/stb at once, with no response.
//  Handshake: command accepted on cmd_valid & cmd_ready; cmd fields registered at accept.
//  Bus transfer: cyc/stb/we/adr/dat asserted the cycle after the FSM enters an access state.
//   - Held stable until wbm_ack_i; cyc/stb low the cycle after ack.
//   - Read data is captured on the ack cycle; at least one idle cycle separates transfers.
//   - Ack timeout: cyc/stb dropped after ACK_TIMEOUT cycles with no ack; then RESP with err=1.
//  Status word (read at 0x04): bit0 scan_enable, bit1 proc_go, bit2 halt.
//  FSM states:
//   IDLE -> (op0) W_DATA | (op1) W_CTRL | (op2) R_STAT | (op3) RESP with err
//   W_DATA: write 0x00 <- cmd_data -> W_GO
//   W_GO: write 0x04 <- 32'h1 (scan_go=1, proc_go cleared; scan needs proc_go=0) -> POLL
//   POLL: read 0x04; set 'seen' when bit0=1; next POLL until seen & bit0=0 -> R_DATA
//   Poll exhausted: after POLL_MAX reads without seen-then-low -> RESP, err=1
//   R_DATA: read 0x00; capture -> RESP with data
//   W_CTRL: write 0x04 <- {30'h0, cmd_data[0], 1'b0} -> RESP, data 0
//   R_STAT: read 0x04 -> RESP with {29'h0, wbm_dat_i[2:0]}
//   RESP: rsp_valid=1 for one cycle -> IDLE
//  Poll counter: 9 bits wide; cleared on entering W_GO. 'seen' is cleared at command accept.
//  Idle gap: the idle cycle between POLL end and R_DATA guarantees the scan_done update has
//   landed before readback.
//  cmd_valid held through RESP is not accepted until the FSM is back in IDLE (no pipelining).
//  wbm_dat_i is ignored outside read-ack cycles; a stray ack while idle is ignored.
// STRUCTURE
//  Package scan_wb_pkg: op codes, register addresses 0x00/0x04, status bit indices, FSM enum.
//  Sub-module wb_single_xfer: one-transfer engine.
//   - Inputs: start, we, adr, wdata.
//   - Outputs: done, err, rdata; owns cyc/stb and the ack-timeout counter.
//  Top level holds the command FSM, poll counter, 'seen' flag and response registers.
// TESTING
//  SCAN_XCHG, data 0xA5A5_0F0F, slave model with 32-cycle scan_enable window and result
//   0x1234_5678 -> writes 0x00=A5A50F0F then 0x04=1 -> rsp_data=0x12345678, err=0.
//  SET_PROC data=1 -> single write 0x04=0x2 -> rsp_valid, data 0, err=0.
//  Then READ_STATUS with halt=1 -> rsp_data=0x6.
//  Slave never acks -> cyc low after 15 cycles -> rsp_err=1 -> cmd_ready=1 next cycle.
//  scan_enable stuck 0 -> exactly 256 status reads -> rsp_err=1.
//  Op 3 -> rsp_err=1, no bus activity.
//  rst_n low mid-POLL with cyc=1 -> cyc/stb low immediately, no rsp_valid.
//  After release, cmd_ready=1 and the next SCAN_XCHG completes normally.

Source files
------------

// File: rtl/scan_wb_pkg.sv
// Shared definitions for the scan/proc-control Wishbone initiator.
package scan_wb_pkg;

  localparam logic [1:0] OP_SCAN_XCHG   = 2'd0;
  localparam logic [1:0] OP_SET_PROC    = 2'd1;
  localparam logic [1:0] OP_READ_STATUS = 2'd2;
  localparam logic [1:0] OP_RSVD        = 2'd3;

  localparam logic [31:0] ADR_DATA = 32'h0000_0000;
  localparam logic [31:0] ADR_CTRL = 32'h0000_0004;

  // Status word bit positions (control/status register)
  localparam int ST_SCAN_EN = 0;
  localparam int ST_PROC_GO = 1;
  localparam int ST_HALT    = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_W_DATA, S_W_GO, S_POLL, S_R_DATA, S_W_CTRL, S_R_STAT, S_RESP
  } state_t;

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic transfer per start pulse, with an ack timeout.
// done/err pulse for one cycle, the cycle after cyc drops.
module wb_single_xfer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  assign bus_stb = bus_cyc;
  assign bus_sel = 4'hF;

  // Launch on start, hold address/data until ack or timeout, capture read data on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_cyc   <= 1'b0;
      bus_we    <= 1'b0;
      bus_adr   <= '0;
      bus_wdata <= '0;
      wait_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (bus_cyc) begin
        if (bus_ack) begin
          bus_cyc <= 1'b0;
          done    <= 1'b1;
          if (!bus_we) rdata <= bus_rdata;
        end else if (wait_cnt == TW'(ACK_TIMEOUT - 1)) begin
          bus_cyc <= 1'b0;
          done    <= 1'b1;
          err     <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else if (start) begin
        bus_cyc   <= 1'b1;
        bus_we    <= we;
        bus_adr   <= adr;
        bus_wdata <= wdata;
        wait_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/scan_wb_initiator.sv
// Host-command to Wishbone register-sequence engine for the scan/proc-control slave.
module scan_wb_initiator
  import scan_wb_pkg::*;
#(
  parameter int POLL_MAX    = 256,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  state_t      state;
  logic        x_start, x_we, x_done, x_err;
  logic [31:0] x_adr, x_wdata, x_rdata;
  logic [8:0]  poll_cnt;
  logic        seen;

  wb_single_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (x_start),
    .we        (x_we),
    .adr       (x_adr),
    .wdata     (x_wdata),
    .done      (x_done),
    .err       (x_err),
    .rdata     (x_rdata),
    .bus_cyc   (wbm_cyc_o),
    .bus_stb   (wbm_stb_o),
    .bus_we    (wbm_we_o),
    .bus_sel   (wbm_sel_o),
    .bus_adr   (wbm_adr_o),
    .bus_wdata (wbm_dat_o),
    .bus_rdata (wbm_dat_i),
    .bus_ack   (wbm_ack_i)
  );

  // Command FSM: each access state issues one start pulse on entry and waits for done.
  // Any transfer error in an access state short-circuits to an error response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      x_start   <= 1'b0;
      x_we      <= 1'b0;
      x_adr     <= '0;
      x_wdata   <= '0;
      poll_cnt  <= '0;
      seen      <= 1'b0;
    end else begin
      x_start   <= 1'b0;
      rsp_valid <= 1'b0;
      if (state != S_IDLE && state != S_RESP && x_done && x_err) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_data  <= '0;
      end else begin
        case (state)
          S_IDLE: if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            seen      <= 1'b0;
            case (cmd_op)
              OP_SCAN_XCHG: begin
                state <= S_W_DATA; x_start <= 1'b1; x_we <= 1'b1;
                x_adr <= ADR_DATA; x_wdata <= cmd_data;
              end
              OP_SET_PROC: begin
                state <= S_W_CTRL; x_start <= 1'b1; x_we <= 1'b1;
                x_adr <= ADR_CTRL; x_wdata <= {30'h0, cmd_data[0], 1'b0};
              end
              OP_READ_STATUS: begin
                state <= S_R_STAT; x_start <= 1'b1; x_we <= 1'b0;
                x_adr <= ADR_CTRL; x_wdata <= '0;
              end
              OP_RSVD: begin
                state <= S_RESP; rsp_valid <= 1'b1; rsp_err <= 1'b1; rsp_data <= '0;
              end
            endcase
          end
          S_W_DATA: if (x_done) begin
            // scan_go with proc_go cleared: the scan cannot run while the processor is released
            state <= S_W_GO; x_start <= 1'b1; x_we <= 1'b1;
            x_adr <= ADR_CTRL; x_wdata <= 32'h1; poll_cnt <= '0;
          end
          S_W_GO: if (x_done) begin
            state <= S_POLL; x_start <= 1'b1; x_we <= 1'b0; x_adr <= ADR_CTRL;
          end
          S_POLL: if (x_done) begin
            poll_cnt <= poll_cnt + 1'b1;
            if (seen && !x_rdata[ST_SCAN_EN]) begin
              state <= S_R_DATA; x_start <= 1'b1; x_we <= 1'b0; x_adr <= ADR_DATA;
            end else if (poll_cnt == 9'(POLL_MAX - 1)) begin
              state <= S_RESP; rsp_valid <= 1'b1; rsp_err <= 1'b1; rsp_data <= '0;
            end else begin
              seen    <= seen | x_rdata[ST_SCAN_EN];
              x_start <= 1'b1;
            end
          end
          S_R_DATA: if (x_done) begin
            state <= S_RESP; rsp_valid <= 1'b1; rsp_err <= 1'b0; rsp_data <= x_rdata;
          end
          S_W_CTRL: if (x_done) begin
            state <= S_RESP; rsp_valid <= 1'b1; rsp_err <= 1'b0; rsp_data <= '0;
          end
          S_R_STAT: if (x_done) begin
            state <= S_RESP; rsp_valid <= 1'b1; rsp_err <= 1'b0;
            rsp_data <= {29'h0, x_rdata[ST_HALT], x_rdata[ST_PROC_GO], x_rdata[ST_SCAN_EN]};
          end
          S_RESP: begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_wb_initiator.sv
// Directed bench for scan_wb_initiator with a behavioural scan/proc-control slave.
module tb_scan_wb_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;

  scan_wb_initiator dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic        ack_en = 1'b1, stuck = 1'b0, halt = 1'b0;
  logic [31:0] result = 32'h1234_5678;
  logic        ack = 1'b0, scan_en = 1'b0, proc_go = 1'b0;
  logic [31:0] data_reg = 32'h0, data_in = 32'h0;
  int          scan_cnt = 0, wr_cnt = 0, rd4_cnt = 0, rd0_cnt = 0;
  logic [31:0] wa [16];
  logic [31:0] wd [16];

  assign wbm_ack_i = ack;
  assign wbm_dat_i = ack ? ((wbm_adr_o == 32'h4) ? {29'h0, halt, proc_go, scan_en} : data_reg)
                         : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    ack <= ack_en && wbm_cyc_o && wbm_stb_o && !ack;
    if (scan_cnt != 0) begin
      scan_cnt <= scan_cnt - 1;
      if (scan_cnt == 1) begin scan_en <= 1'b0; data_reg <= result; end
    end
    if (ack && wbm_cyc_o && wbm_stb_o) begin
      if (wbm_we_o) begin
        wa[wr_cnt % 16] <= wbm_adr_o;
        wd[wr_cnt % 16] <= wbm_dat_o;
        wr_cnt <= wr_cnt + 1;
        if (wbm_adr_o == 32'h0) begin
          data_reg <= wbm_dat_o; data_in <= wbm_dat_o;
        end else begin
          proc_go <= wbm_dat_o[1];
          if (wbm_dat_o[0] && !stuck) begin scan_en <= 1'b1; scan_cnt <= 32; end
        end
      end else if (wbm_adr_o == 32'h4) rd4_cnt <= rd4_cnt + 1;
      else rd0_cnt <= rd0_cnt + 1;
    end
  end

  // ---------------- bus monitors ----------------
  logic        cyc_q = 1'b0, ack_q = 1'b0, we_q = 1'b0, prot_err = 1'b0;
  logic [31:0] adr_q = 32'h0, dat_q = 32'h0;
  int          cyc_len = 0, last_len = 0, bus_cnt = 0, rsp_cnt = 0;

  always @(posedge clk) begin
    cyc_q <= wbm_cyc_o; ack_q <= wbm_ack_i; we_q <= wbm_we_o;
    adr_q <= wbm_adr_o; dat_q <= wbm_dat_o;
    if (wbm_stb_o !== wbm_cyc_o) prot_err <= 1'b1;
    if (wbm_cyc_o && wbm_sel_o !== 4'hF) prot_err <= 1'b1;
    if (cyc_q && ack_q && wbm_cyc_o) prot_err <= 1'b1;
    if (cyc_q && wbm_cyc_o && (wbm_we_o !== we_q || wbm_adr_o !== adr_q || wbm_dat_o !== dat_q))
      prot_err <= 1'b1;
    if (wbm_cyc_o && !cyc_q) bus_cnt <= bus_cnt + 1;
    if (wbm_cyc_o) cyc_len <= cyc_len + 1;
    else if (cyc_len != 0) begin last_len <= cyc_len; cyc_len <= 0; end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- checking helpers ----------------
  int          passed = 0, total = 0;
  logic        got;
  logic [31:0] r_data;
  logic        r_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    got = 1'b0; r_data = 32'hX; r_err = 1'bX;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin got = 1'b1; r_data = rsp_data; r_err = rsp_err; break; end
      @(negedge clk);
    end
    chk({tag, "_rsp_seen"}, {31'h0, got}, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_w, base_r4, base_r0, base_b, base_rsp, n;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
    chk("rst_cyc_stb",   {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    chk("rst_we",        {31'h0, wbm_we_o},  32'h0);
    chk("rst_adr",       wbm_adr_o, 32'h0);
    chk("rst_dat",       wbm_dat_o, 32'h0);
    rst_n = 1'b1;

    // SCAN_XCHG: data write, scan go, polling through the 32-cycle window, readback
    base_w = wr_cnt;
    send(2'd0, 32'hA5A5_0F0F);
    wait_rsp("scan", 2000);
    chk("scan_data", r_data, 32'h1234_5678);
    chk("scan_err",  {31'h0, r_err}, 32'h0);
    chk("scan_nwr",  wr_cnt - base_w, 32'd2);
    chk("scan_wa0",  wa[base_w % 16], 32'h0);
    chk("scan_wd0",  wd[base_w % 16], 32'hA5A5_0F0F);
    chk("scan_wa1",  wa[(base_w + 1) % 16], 32'h4);
    chk("scan_wd1",  wd[(base_w + 1) % 16], 32'h1);
    chk("scan_slv_in", data_in, 32'hA5A5_0F0F);
    @(negedge clk);
    chk("scan_ready_after", {31'h0, cmd_ready}, 32'h1);

    // SET_PROC 1: one write of 0x2 to control
    base_w = wr_cnt; base_b = bus_cnt;
    send(2'd1, 32'hFFFF_FFF1);
    wait_rsp("setp", 200);
    chk("setp_data", r_data, 32'h0);
    chk("setp_err",  {31'h0, r_err}, 32'h0);
    chk("setp_nbus", bus_cnt - base_b, 32'd1);
    chk("setp_wa",   wa[base_w % 16], 32'h4);
    chk("setp_wd",   wd[base_w % 16], 32'h2);

    // READ_STATUS with halt and proc_go set
    halt = 1'b1;
    send(2'd2, 32'h0);
    wait_rsp("stat", 200);
    chk("stat_data", r_data, 32'h6);
    chk("stat_err",  {31'h0, r_err}, 32'h0);

    // Slave never acks: 15-cycle bus cycle then error, ready the next cycle
    ack_en = 1'b0;
    send(2'd1, 32'h0);
    wait_rsp("tmo", 200);
    chk("tmo_err", {31'h0, r_err}, 32'h1);
    chk("tmo_len", last_len, 32'd15);
    @(negedge clk);
    chk("tmo_ready", {31'h0, cmd_ready}, 32'h1);
    ack_en = 1'b1;

    // scan_enable never rises: exactly POLL_MAX status reads then error
    stuck = 1'b1; base_r4 = rd4_cnt; base_r0 = rd0_cnt;
    send(2'd0, 32'h5555_AAAA);
    wait_rsp("stuck", 6000);
    chk("stuck_err",   {31'h0, r_err}, 32'h1);
    chk("stuck_polls", rd4_cnt - base_r4, 32'd256);
    chk("stuck_rd0",   rd0_cnt - base_r0, 32'd0);
    stuck = 1'b0;

    // Reserved op: error, no bus activity
    base_b = bus_cnt;
    send(2'd3, 32'h0);
    wait_rsp("op3", 20);
    chk("op3_err",  {31'h0, r_err}, 32'h1);
    chk("op3_data", r_data, 32'h0);
    chk("op3_nbus", bus_cnt - base_b, 32'd0);

    // Reset in the middle of a poll read
    base_r4 = rd4_cnt;
    send(2'd0, 32'h0000_0001);
    n = 0;
    while (!(wbm_cyc_o && !wbm_we_o && wbm_adr_o == 32'h4 && rd4_cnt > base_r4) && n < 500) begin
      @(negedge clk); n++;
    end
    chk("mid_poll_found", {31'h0, wbm_cyc_o}, 32'h1);
    rst_n = 1'b0;
    base_rsp = rsp_cnt;
    #1;
    chk("mid_rst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_cnt - base_rsp, 32'd0);
    chk("mid_rst_ready",  {31'h0, cmd_ready}, 32'h1);

    // Normal exchange after recovery
    result = 32'hCAFE_0001;
    send(2'd0, 32'h0BAD_F00D);
    wait_rsp("post", 2000);
    chk("post_data",   r_data, 32'hCAFE_0001);
    chk("post_err",    {31'h0, r_err}, 32'h0);
    chk("post_slv_in", data_in, 32'h0BAD_F00D);

    chk("bus_protocol", {31'h0, prot_err}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
